// File: rtl/lsp_hist_update.sv
// lsp_hist_update: shifts/presets the NP-row predictor history in shared memory,
// copying one element per cycle through a pipelined read/write engine.
module lsp_hist_update #(
    parameter int M = 10,
    parameter int NP = 4,
    parameter int AW = 11,
    parameter int DW = 32,
    parameter int STRIDE_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] histAddr,
    input  logic [AW-1:0] srcAddr,
    input  logic [DW-1:0] memIn,
    output logic [AW-1:0] memReadAddr,
    output logic [AW-1:0] memWriteAddr,
    output logic [DW-1:0] memOut,
    output logic          memWriteEn,
    output logic          busy,
    output logic          done
);
    localparam int KW = $clog2(NP) + 1;
    localparam int JW = $clog2(M + 1);
    localparam logic [1:0] PRESET = 2'd1, SHIFT = 2'd2, NOP = 2'd3;
    typedef enum logic [1:0] {IDLE, ROW, COPY, DONE} state_t;
    state_t state, stateNxt;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic [1:0] md;
    logic [AW-1:0] hist, src;
    logic lastCopy, fromSrc;
    assign lastCopy = state == COPY && j == JW'(M);
    // row 0 of an UPDATE is the insert, which reads the new vector like PRESET does
    assign fromSrc = md == PRESET || k == '0;
    // read data is forwarded straight to the write port the cycle it arrives
    assign memOut = memWriteEn ? memIn : '0;
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: if (start) stateNxt = (mode == NOP || (mode == SHIFT && NP == 1)) ? DONE : ROW;
            ROW: stateNxt = COPY;
            COPY: if (lastCopy) stateNxt = (k == '0 || (md == SHIFT && k == KW'(1))) ? DONE : ROW;
            default: stateNxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= stateNxt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memReadAddr <= '0;
            memWriteAddr <= '0;
            memWriteEn <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            k <= '0;
            j <= '0;
            md <= '0;
            hist <= '0;
            src <= '0;
        end else begin
            done <= stateNxt == DONE;
            busy <= stateNxt == ROW || stateNxt == COPY;
            memWriteEn <= state == COPY && j != JW'(M);
            if (state == IDLE && start) begin
                md <= mode;
                hist <= histAddr;
                src <= srcAddr;
                k <= KW'(NP - 1);
            end
            if (state == ROW) begin
                memReadAddr <= fromSrc ? src : hist + (AW'(k - KW'(1)) << STRIDE_LOG2);
                memWriteAddr <= hist + (AW'(k) << STRIDE_LOG2);
                j <= '0;
            end
            if (state == COPY) begin
                j <= j + 1'b1;
                if (j < JW'(M - 1)) memReadAddr <= memReadAddr + 1'b1;
                if (j != '0 && j != JW'(M)) memWriteAddr <= memWriteAddr + 1'b1;
                if (lastCopy && k != '0) k <= k - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsp_hist_update.sv
// tb_lsp_hist_update: directed vectors for the history-update engine against a
// synchronous-read memory model, plus reset, restart and NP=1 corner sequences.
module tb_lsp_hist_update;
    logic clk = 0, reset = 0;
    logic start = 0, start1 = 0;
    logic [1:0] mode = 0, mode1 = 0;
    logic [10:0] histAddr = 0, srcAddr = 0, histAddr1 = 0, srcAddr1 = 0;
    logic [31:0] memIn, memOut, memIn1, memOut1;
    logic [10:0] memReadAddr, memWriteAddr, memReadAddr1, memWriteAddr1;
    logic memWriteEn, busy, done, memWriteEn1, busy1, done1;
    logic [31:0] mem0 [0:2047];
    logic [31:0] mem1 [0:2047];
    logic pokeEn = 0, pokeSel = 0;
    logic [10:0] pokeAddr = 0;
    logic [31:0] pokeData = 0;
    int wr0 = 0, wr1 = 0, nChecks = 0, nFail = 0;

    always #5 clk = ~clk;

    lsp_hist_update dut (.clk(clk), .reset(reset), .start(start), .mode(mode),
        .histAddr(histAddr), .srcAddr(srcAddr), .memIn(memIn), .memReadAddr(memReadAddr),
        .memWriteAddr(memWriteAddr), .memOut(memOut), .memWriteEn(memWriteEn),
        .busy(busy), .done(done));

    lsp_hist_update #(.M(16), .NP(1), .STRIDE_LOG2(4)) dut1 (.clk(clk), .reset(reset),
        .start(start1), .mode(mode1), .histAddr(histAddr1), .srcAddr(srcAddr1),
        .memIn(memIn1), .memReadAddr(memReadAddr1), .memWriteAddr(memWriteAddr1),
        .memOut(memOut1), .memWriteEn(memWriteEn1), .busy(busy1), .done(done1));

    always @(posedge clk) begin
        memIn <= mem0[memReadAddr];
        memIn1 <= mem1[memReadAddr1];
        if (memWriteEn) begin
            mem0[memWriteAddr] <= memOut;
            wr0 <= wr0 + 1;
        end
        if (memWriteEn1) begin
            mem1[memWriteAddr1] <= memOut1;
            wr1 <= wr1 + 1;
        end
        if (pokeEn && !pokeSel) mem0[pokeAddr] <= pokeData;
        if (pokeEn && pokeSel) mem1[pokeAddr] <= pokeData;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic s, input logic [10:0] a, input logic [31:0] d);
        pokeSel = s;
        pokeAddr = a;
        pokeData = d;
        pokeEn = 1;
        @(posedge clk);
        #1;
        pokeEn = 0;
    endtask

    // rows k = 100*k + i at 0x040 + 16k, new vector srcBase + i at 0x300
    task automatic preload(input logic [31:0] srcBase);
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 10; i++) poke(0, 11'(32'h40 + 16 * r + i), 32'(100 * r + i));
        for (int i = 0; i < 10; i++) poke(0, 11'(32'h300 + i), srcBase + 32'(i));
    endtask

    task automatic runOp(input logic [1:0] m, input int pulse, output int doneCyc,
                         output int writes, output bit busyHigh);
        int w;
        w = wr0;
        busyHigh = 0;
        doneCyc = -1;
        mode = m;
        histAddr = 11'h040;
        srcAddr = 11'h300;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        mode = 2'd3;
        histAddr = 11'h7f0;
        srcAddr = 11'h000;
        for (int c = 1; c <= 300; c++) begin
            if (done) begin
                doneCyc = c;
                break;
            end
            busyHigh |= busy;
            start = (c == pulse);
            @(posedge clk);
            #1;
        end
        start = 0;
        writes = wr0 - w;
    endtask

    typedef struct {
        logic [1:0] m;
        logic [31:0] srcBase;
        int expDone;
        int expWr;
        logic [3:0][31:0] row;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int dc, wc, extra;
        bit bh;
        vecs[0] = '{2'd0, 32'd900, 49, 40, {32'd200, 32'd100, 32'd0, 32'd900}};
        vecs[1] = '{2'd1, 32'h12340000, 49, 40, {4{32'h12340000}}};
        vecs[2] = '{2'd2, 32'd900, 37, 30, {32'd200, 32'd100, 32'd0, 32'd0}};
        vecs[3] = '{2'd3, 32'd900, 1, 0, {32'd300, 32'd200, 32'd100, 32'd0}};
        repeat (2) @(posedge clk);
        #1;
        check("rst memReadAddr", 32'(memReadAddr), 0);
        check("rst memWriteAddr", 32'(memWriteAddr), 0);
        check("rst memOut", memOut, 0);
        check("rst memWriteEn", 32'(memWriteEn), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        reset = 1;

        for (int v = 0; v < 4; v++) begin
            preload(vecs[v].srcBase);
            runOp(vecs[v].m, 0, dc, wc, bh);
            check($sformatf("v%0d done cycle", v), dc, vecs[v].expDone);
            check($sformatf("v%0d writes", v), wc, vecs[v].expWr);
            check($sformatf("v%0d busy in done", v), 32'(busy), 0);
            check($sformatf("v%0d busy seen", v), 32'(bh), 32'(vecs[v].m != 2'd3));
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse width", v), 32'(done), 0);
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < 10; i++)
                    check($sformatf("v%0d row%0d[%0d]", v, r, i), mem0[11'(32'h40 + 16 * r + i)],
                          vecs[v].row[r] + 32'(i));
        end

        // start at cycle 5 and in the DONE cycle must both be dropped
        preload(900);
        runOp(2'd0, 5, dc, wc, bh);
        check("pulse done cycle", dc, 49);
        check("pulse writes", wc, 40);
        start = 1;
        mode = 2'd0;
        @(posedge clk);
        #1;
        start = 0;
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            extra += int'(busy) + int'(done);
            @(posedge clk);
            #1;
        end
        check("start in done ignored", extra, 0);

        // back-to-back: second start in the first IDLE cycle
        preload(900);
        runOp(2'd0, 0, dc, wc, bh);
        @(posedge clk);
        #1;
        runOp(2'd0, 0, dc, wc, bh);
        check("restart done cycle", dc, 49);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("restart row3[%0d]", i), mem0[11'(32'h70 + i)], 32'(100 + i));
            check($sformatf("restart row1[%0d]", i), mem0[11'(32'h50 + i)], 32'(900 + i));
        end

        // reset during cycle 20: row3 done, row2 elements 0..4 written
        preload(900);
        mode = 2'd0;
        histAddr = 11'h040;
        srcAddr = 11'h300;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (19) @(posedge clk);
        #1;
        check("pre-reset memWriteEn", 32'(memWriteEn), 1);
        reset = 0;
        #1;
        check("async memWriteEn", 32'(memWriteEn), 0);
        check("async busy", 32'(busy), 0);
        check("async memWriteAddr", 32'(memWriteAddr), 0);
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            extra += int'(done);
        end
        check("no done on reset", extra, 0);
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rst row3[%0d]", i), mem0[11'(32'h70 + i)], 32'(200 + i));
            check($sformatf("rst row2[%0d]", i), mem0[11'(32'h60 + i)], 32'(i < 5 ? 100 + i : 200 + i));
            check($sformatf("rst row1[%0d]", i), mem0[11'(32'h50 + i)], 32'(100 + i));
            check($sformatf("rst row0[%0d]", i), mem0[11'(32'h40 + i)], 32'(i));
        end
        runOp(2'd0, 0, dc, wc, bh);
        check("post-reset done cycle", dc, 49);
        check("post-reset writes", wc, 40);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("post row3[%0d]", i), mem0[11'(32'h70 + i)], 32'(i < 5 ? 100 + i : 200 + i));
            check($sformatf("post row2[%0d]", i), mem0[11'(32'h60 + i)], 32'(100 + i));
            check($sformatf("post row1[%0d]", i), mem0[11'(32'h50 + i)], 32'(i));
            check($sformatf("post row0[%0d]", i), mem0[11'(32'h40 + i)], 32'(900 + i));
        end

        // M=16, NP=1: UPDATE only rewrites row 0
        for (int i = 0; i < 16; i++) begin
            poke(1, 11'(32'h80 + i), 32'(50 + i));
            poke(1, 11'(32'h90 + i), 32'd77);
            poke(1, 11'(32'h400 + i), 32'(700 + i));
        end
        wc = wr1;
        dc = -1;
        mode1 = 2'd0;
        histAddr1 = 11'h080;
        srcAddr1 = 11'h400;
        start1 = 1;
        @(posedge clk);
        #1;
        start1 = 0;
        for (int c = 1; c <= 100; c++) begin
            if (done1) begin
                dc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("np1 done cycle", dc, 19);
        check("np1 writes", wr1 - wc, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("np1 row0[%0d]", i), mem1[11'(32'h80 + i)], 32'(700 + i));
            check($sformatf("np1 row1[%0d]", i), mem1[11'(32'h90 + i)], 32'd77);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
